// File: rtl/immediate_decode_stage.sv
// immediate_decode_stage
//   Registered immediate-decode stage between fetch and execute. Classifies the
//   instruction format, builds the sign-extended XLEN-bit immediate and flags
//   unknown opcodes. A 2-entry skid buffer (output register + skid register)
//   keeps one instruction per cycle under backpressure while in_ready and all
//   outputs come straight from flops.
//
//   Optional feature: define RVC_EN to decode 16-bit compressed words
//   (in_instruction[1:0] != 2'b11). Without it such words are flagged illegal
//   and out_compressed is tied to 0.
//
// Ports
//   clk, rst_n       clock, synchronous active-low reset
//   flush            drop every buffered entry at the next edge
//   in_valid/ready   instruction handshake, in_instruction = raw word
//   out_valid/ready  result handshake
//   out_immediate    sign-extended immediate (XLEN)
//   out_format       0=R 1=I 2=S 3=B 4=U 5=J
//   out_illegal      opcode not recognised
//   out_compressed   entry was a 16-bit instruction
//   out_instruction  pass-through of the accepted word
module immediate_decode_stage #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [ILEN-1:0] in_instruction,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_immediate,
    output logic [2:0]      out_format,
    output logic            out_illegal,
    output logic            out_compressed,
    output logic [ILEN-1:0] out_instruction
);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
        logic            compressed;
        logic [ILEN-1:0] instr;
    } entry_t;

    entry_t     dec;
    entry_t     out_q;
    entry_t     skid_q;
    logic       out_vld;
    logic       skid_vld;
    logic [31:0] imm32;
    logic [6:0]  opcode;
    logic        in_xfer;
    logic        out_xfer;

    assign opcode = in_instruction[6:0];

    // ---------------- input-side decode (registered into the buffer) -------
    // Every immediate is first formed as a 32-bit sign-extended value and
    // then widened once, so the U-type sign extension for XLEN=64 and all
    // other formats share the same final extension.
    always_comb begin
        imm32          = '0;
        dec            = '0;
        dec.instr      = in_instruction;
        dec.fmt        = FMT_R;
`ifdef RVC_EN
        if (in_instruction[1:0] != 2'b11) begin
            dec.compressed = 1'b1;
            unique case ({in_instruction[1:0], in_instruction[15:13]})
                5'b01_000, 5'b01_010: begin        // C.ADDI / C.LI
                    dec.fmt = FMT_I;
                    imm32   = {{26{in_instruction[12]}}, in_instruction[12],
                               in_instruction[6:2]};
                end
                5'b01_101, 5'b01_001: begin        // C.J / C.JAL
                    dec.fmt = FMT_J;
                    imm32   = {{20{in_instruction[12]}}, in_instruction[12],
                               in_instruction[8], in_instruction[10:9],
                               in_instruction[6], in_instruction[7],
                               in_instruction[2], in_instruction[11],
                               in_instruction[5:3], 1'b0};
                end
                5'b01_110, 5'b01_111: begin        // C.BEQZ / C.BNEZ
                    dec.fmt = FMT_B;
                    imm32   = {{23{in_instruction[12]}}, in_instruction[12],
                               in_instruction[6:5], in_instruction[2],
                               in_instruction[11:10], in_instruction[4:3], 1'b0};
                end
                5'b00_010, 5'b00_110: begin        // C.LW / C.SW (zero-extended)
                    dec.fmt = in_instruction[15] ? FMT_S : FMT_I;
                    imm32   = {25'b0, in_instruction[5], in_instruction[12:10],
                               in_instruction[6], 2'b00};
                end
                default: dec.illegal = 1'b1;
            endcase
        end else
`endif
        begin
            // Words with [1:0] != 2'b11 match no opcode below and land in
            // default, which flags them illegal when RVC_EN is off.
            unique case (opcode)
                7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: begin
                    dec.fmt = FMT_I;
                    imm32   = {{20{in_instruction[31]}}, in_instruction[31:20]};
                end
                7'b0100011: begin
                    dec.fmt = FMT_S;
                    imm32   = {{20{in_instruction[31]}}, in_instruction[31:25],
                               in_instruction[11:7]};
                end
                7'b1100011: begin
                    dec.fmt = FMT_B;
                    imm32   = {{19{in_instruction[31]}}, in_instruction[31],
                               in_instruction[7], in_instruction[30:25],
                               in_instruction[11:8], 1'b0};
                end
                7'b0110111, 7'b0010111: begin
                    dec.fmt = FMT_U;
                    imm32   = {in_instruction[31:12], 12'b0};
                end
                7'b1101111: begin
                    dec.fmt = FMT_J;
                    imm32   = {{11{in_instruction[31]}}, in_instruction[31],
                               in_instruction[19:12], in_instruction[20],
                               in_instruction[30:21], 1'b0};
                end
                7'b0110011: dec.fmt = FMT_R;
                7'b0011011: begin                  // OP-IMM-32, RV64 only
                    if (XLEN == 64) begin
                        dec.fmt = FMT_I;
                        imm32   = {{20{in_instruction[31]}}, in_instruction[31:20]};
                    end else begin
                        dec.illegal = 1'b1;
                    end
                end
                7'b0111011: begin                  // OP-32, RV64 only
                    if (XLEN != 64) dec.illegal = 1'b1;
                end
                default: dec.illegal = 1'b1;
            endcase
        end
        dec.imm = XLEN'($signed(imm32));
    end

    // ---------------- 2-entry skid buffer -----------------------------------
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_vld && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
            out_q    <= '0;
            skid_q   <= '0;
        end else if (flush) begin
            // Data is left in place; only the valids matter once flushed.
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
        end else if (out_xfer || !out_vld) begin
            // Output register frees up this edge: the skid entry is older
            // than anything on the input, and in_ready is low while it is
            // held, so no input can be lost here.
            if (skid_vld) begin
                out_q    <= skid_q;
                out_vld  <= 1'b1;
                skid_vld <= 1'b0;
            end else if (in_xfer) begin
                out_q    <= dec;
                out_vld  <= 1'b1;
            end else begin
                out_vld  <= 1'b0;
            end
        end else if (in_xfer) begin
            skid_q   <= dec;
            skid_vld <= 1'b1;
        end
    end

    assign in_ready        = ~skid_vld;
    assign out_valid       = out_vld;
    assign out_immediate   = out_q.imm;
    assign out_format      = out_q.fmt;
    assign out_illegal     = out_q.illegal;
    assign out_instruction = out_q.instr;
`ifdef RVC_EN
    assign out_compressed  = out_q.compressed;
`else
    assign out_compressed  = 1'b0;
`endif

endmodule

// File: tb/tb_immediate_decode_stage.sv
// Directed bench for immediate_decode_stage. A 32-bit and a 64-bit instance
// share the same inputs so RV64-only decode can be checked side by side.
module tb_immediate_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instruction;

    logic        in_ready,  in_ready64;
    logic        out_valid, out_valid64;
    logic [31:0] out_immediate;
    logic [63:0] out_immediate64;
    logic [2:0]  out_format, out_format64;
    logic        out_illegal, out_illegal64;
    logic        out_compressed, out_compressed64;
    logic [31:0] out_instruction, out_instruction64;

    int n_assert = 0;
    int n_fail   = 0;

    immediate_decode_stage #(.XLEN(32), .ILEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instruction(in_instruction),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_immediate(out_immediate), .out_format(out_format),
        .out_illegal(out_illegal), .out_compressed(out_compressed),
        .out_instruction(out_instruction)
    );

    immediate_decode_stage #(.XLEN(64), .ILEN(32)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_instruction(in_instruction),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_immediate(out_immediate64), .out_format(out_format64),
        .out_illegal(out_illegal64), .out_compressed(out_compressed64),
        .out_instruction(out_instruction64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and land 1 time unit after it for sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] imm,
                           input logic [2:0] fmt, input logic ill, input logic [31:0] word);
        chk({tag, ".valid"}, out_valid, 1'b1);
        chk({tag, ".imm"}, out_immediate, imm);
        chk({tag, ".fmt"}, out_format, fmt);
        chk({tag, ".ill"}, out_illegal, ill);
        chk({tag, ".instr"}, out_instruction, word);
    endtask

    // Present a single word with out_ready high and sample it next cycle.
    task automatic send_one(input logic [31:0] word);
        in_valid       = 1'b1;
        in_instruction = word;
        out_ready      = 1'b1;
        tick();
        in_valid       = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instruction = 32'h0;
        tick(); tick();

        // reset state
        chk("rst.out_valid", out_valid, 1'b0);
        chk("rst.in_ready", in_ready, 1'b1);
        chk("rst.imm", out_immediate, 32'h0);
        chk("rst.fmt", out_format, 3'd0);
        chk("rst.ill", out_illegal, 1'b0);
        chk("rst.comp", out_compressed, 1'b0);
        chk("rst.instr", out_instruction, 32'h0);
        rst_n = 1'b1;
        tick();

        // back-to-back, full throughput
        in_valid = 1'b1; out_ready = 1'b1; in_instruction = 32'hFFF00093;
        tick(); chk_out("addi", 32'hFFFFFFFF, 3'd1, 1'b0, 32'hFFF00093);
        in_instruction = 32'hFE000EE3;
        tick(); chk_out("beq", 32'hFFFFFFFC, 3'd3, 1'b0, 32'hFE000EE3);
        in_instruction = 32'h123450B7;
        tick(); chk_out("lui", 32'h12345000, 3'd4, 1'b0, 32'h123450B7);
        in_instruction = 32'h0080006F;
        tick(); chk_out("jal", 32'h00000008, 3'd5, 1'b0, 32'h0080006F);
        chk("b2b.in_ready", in_ready, 1'b1);
        in_valid = 1'b0;
        tick(); chk("b2b.drain", out_valid, 1'b0);

        // backpressure: three words offered, two accepted
        out_ready = 1'b0; in_valid = 1'b1; in_instruction = 32'h00500093;
        tick(); chk_out("bp.w1", 32'h5, 3'd1, 1'b0, 32'h00500093);
        chk("bp.rdy1", in_ready, 1'b1);
        in_instruction = 32'h00600093;
        tick(); chk("bp.rdy2", in_ready, 1'b0);
        chk("bp.hold1", out_immediate, 32'h5);
        in_instruction = 32'h00700093;
        tick(); chk("bp.rdy3", in_ready, 1'b0);
        chk("bp.hold2", out_immediate, 32'h5);
        out_ready = 1'b1;
        tick(); chk_out("bp.w2", 32'h6, 3'd1, 1'b0, 32'h00600093);
        chk("bp.rdy4", in_ready, 1'b1);
        tick(); chk_out("bp.w3", 32'h7, 3'd1, 1'b0, 32'h00700093);
        in_valid = 1'b0;
        tick(); chk("bp.empty", out_valid, 1'b0);

        // flush with both entries held and a word offered
        out_ready = 1'b0; in_valid = 1'b1; in_instruction = 32'h01100093;
        tick(); in_instruction = 32'h01200093;
        tick(); chk("fl.full", in_ready, 1'b0);
        flush = 1'b1; in_instruction = 32'h01300093;
        tick(); chk("fl.valid", out_valid, 1'b0);
        chk("fl.rdy", in_ready, 1'b1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick(); chk("fl.dropped", out_valid, 1'b0);

        // reset mid-stream clears data outputs too
        out_ready = 1'b0; in_valid = 1'b1; in_instruction = 32'h01400093;
        tick(); chk("mr.loaded", out_valid, 1'b1);
        rst_n = 1'b0;
        tick(); chk("mr.valid", out_valid, 1'b0);
        chk("mr.rdy", in_ready, 1'b1);
        chk("mr.imm", out_immediate, 32'h0);
        chk("mr.instr", out_instruction, 32'h0);
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        tick();

        // illegal opcode, store, R-type
        send_one(32'h0000007F); chk_out("ill7f", 32'h0, 3'd0, 1'b1, 32'h0000007F);
        send_one(32'hFE000E23); chk_out("sw", 32'hFFFFFFFC, 3'd2, 1'b0, 32'hFE000E23);
        send_one(32'h00000033); chk_out("op", 32'h0, 3'd0, 1'b0, 32'h00000033);

        // RV64 decode versus RV32
        send_one(32'h800000B7);
        chk("lui64.imm", out_immediate64, 64'hFFFFFFFF80000000);
        chk("lui64.fmt", out_format64, 3'd4);
        chk("lui32.imm", out_immediate, 32'h80000000);
        send_one(32'h0010009B);
        chk("opimm32.64.imm", out_immediate64, 64'h1);
        chk("opimm32.64.fmt", out_format64, 3'd1);
        chk("opimm32.64.ill", out_illegal64, 1'b0);
        chk("opimm32.32.ill", out_illegal, 1'b1);
        chk("opimm32.32.imm", out_immediate, 32'h0);

        // compressed C.LI
        send_one(32'h000050FD);
`ifdef RVC_EN
        chk_out("cli", 32'hFFFFFFFF, 3'd1, 1'b0, 32'h000050FD);
        chk("cli.comp", out_compressed, 1'b1);
`else
        chk_out("cli", 32'h0, 3'd0, 1'b1, 32'h000050FD);
        chk("cli.comp", out_compressed, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
